// File: rtl/fp_mac_pkg.sv
// Shared definitions for the FP MAC operand path.
//   FP_DATA_W    : default operand width (half-precision word)
//   FP_ADDR_W    : default SRAM address width
//   SRAM_DEPTH   : operand pairs per run, shared with the load sequencer
//   FP_READ_WAIT : default cs/oe low time before read data is sampled
//   rd_state_e   : operand reader state encoding
package fp_mac_pkg;

  localparam int unsigned FP_DATA_W    = 16;
  localparam int unsigned FP_ADDR_W    = 4;
  localparam int unsigned SRAM_DEPTH   = 8;
  localparam int unsigned FP_READ_WAIT = 2;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'b00,
    RD_READ    = 2'b01,
    RD_PRESENT = 2'b10,
    RD_DONE    = 2'b11
  } rd_state_e;

endpackage

// File: rtl/sram_read_timer.sv
// Wait counter for asynchronous SRAM accesses.
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   clr     : synchronous clear to zero (wins over en)
//   en      : count one cycle of the access
//   expired : high during the READ_WAIT-th enabled cycle after a clear
// The count saturates at READ_WAIT, so holding en beyond expiry is harmless.
module sram_read_timer #(
  parameter int unsigned READ_WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(READ_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(READ_WAIT);
  localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(READ_WAIT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign expired = (r_count == CNT_EXP);

endmodule

// File: rtl/sram_operand_reader.sv
// Read side of the operand SRAM pair. On start, walks addresses 0..DEPTH-1,
// reads A[i]/B[i] via the async cs_n/oe_n interface and presents each pair
// to the MAC on a valid/ready stream, then pulses done.
//   clk, rst            : clock, asynchronous active-low reset
//   start               : run request, sampled only in IDLE
//   sram_addr           : address shared by both SRAMs
//   cs_a_n/oe_a_n       : SRAM A chip select / output enable (active low)
//   cs_b_n/oe_b_n       : SRAM B chip select / output enable (active low)
//   data_a, data_b      : SRAM read data
//   op_a, op_b          : registered operands
//   op_valid, op_last   : stream qualifiers; op_last marks index DEPTH-1
//   op_ready            : MAC accept
//   busy                : high outside IDLE
//   done                : one-cycle pulse after the last pair is accepted
module sram_operand_reader
  import fp_mac_pkg::*;
#(
  parameter int unsigned DATA_W    = FP_DATA_W,
  parameter int unsigned ADDR_W    = FP_ADDR_W,
  parameter int unsigned DEPTH     = SRAM_DEPTH,
  parameter int unsigned READ_WAIT = FP_READ_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              cs_a_n,
  output logic              oe_a_n,
  output logic              cs_b_n,
  output logic              oe_b_n,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_valid,
  output logic              op_last,
  input  logic              op_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  rd_state_e         r_state;
  rd_state_e         w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic              w_expired;
  logic              w_last;
  logic              w_read;

  assign w_last = (r_addr == LAST_ADDR);

  // Held in clear outside READ so every access starts from zero.
  sram_read_timer #(
    .READ_WAIT (READ_WAIT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!w_read),
    .en      (w_read),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RD_IDLE;
      r_addr  <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        RD_IDLE: begin
          if (start) r_addr <= '0;
        end
        RD_READ: begin
          if (w_expired) begin
            r_op_a <= data_a;
            r_op_b <= data_b;
          end
        end
        RD_PRESENT: begin
          if (op_ready && !w_last) r_addr <= r_addr + ADDR_W'(1);
        end
        RD_DONE: begin
          r_addr <= '0;
        end
        default: r_addr <= '0;
      endcase
    end
  end

  // Outputs decode the state register only, so op_valid never
  // depends combinationally on op_ready.
  always_comb begin
    w_next   = r_state;
    w_read   = 1'b0;
    op_valid = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (r_state)
      RD_IDLE: begin
        busy = 1'b0;
        if (start) w_next = RD_READ;
      end
      RD_READ: begin
        w_read = 1'b1;
        if (w_expired) w_next = RD_PRESENT;
      end
      RD_PRESENT: begin
        op_valid = 1'b1;
        if (op_ready) w_next = w_last ? RD_DONE : RD_READ;
      end
      RD_DONE: begin
        done   = 1'b1;
        w_next = RD_IDLE;
      end
      default: w_next = RD_IDLE;
    endcase
  end

  assign sram_addr = r_addr;
  assign cs_a_n    = !w_read;
  assign oe_a_n    = !w_read;
  assign cs_b_n    = !w_read;
  assign oe_b_n    = !w_read;
  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign op_last   = op_valid && w_last;

endmodule

// File: tb/tb_sram_operand_reader.sv
module tb_sram_operand_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, op_ready;
  logic [3:0]  sram_addr;
  logic        cs_a_n, oe_a_n, cs_b_n, oe_b_n;
  logic [15:0] data_a, data_b, op_a, op_b;
  logic        op_valid, op_last, busy, done;

  logic        start1, ready1;
  logic [3:0]  addr1;
  logic        cs_a1_n, oe_a1_n, cs_b1_n, oe_b1_n;
  logic [15:0] data_a1, data_b1, op_a1, op_b1;
  logic        op_valid1, op_last1, busy1, done1;

  logic [15:0] mem_a [16];
  logic [15:0] mem_b [16];
  logic        ovr;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  // SRAM models: data only driven while selected; ovr corrupts the bus.
  assign data_a  = ovr ? 16'hBEEF : ((!cs_a_n && !oe_a_n) ? mem_a[sram_addr] : 16'hDEAD);
  assign data_b  = ovr ? 16'hBEEF : ((!cs_b_n && !oe_b_n) ? mem_b[sram_addr] : 16'hDEAD);
  assign data_a1 = (!cs_a1_n && !oe_a1_n) ? mem_a[addr1] : 16'hDEAD;
  assign data_b1 = (!cs_b1_n && !oe_b1_n) ? mem_b[addr1] : 16'hDEAD;

  sram_operand_reader #(.DATA_W(16), .ADDR_W(4), .DEPTH(8), .READ_WAIT(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .sram_addr(sram_addr),
    .cs_a_n(cs_a_n), .oe_a_n(oe_a_n), .cs_b_n(cs_b_n), .oe_b_n(oe_b_n),
    .data_a(data_a), .data_b(data_b), .op_a(op_a), .op_b(op_b),
    .op_valid(op_valid), .op_last(op_last), .op_ready(op_ready),
    .busy(busy), .done(done)
  );

  sram_operand_reader #(.DATA_W(16), .ADDR_W(4), .DEPTH(1), .READ_WAIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .sram_addr(addr1),
    .cs_a_n(cs_a1_n), .oe_a_n(oe_a1_n), .cs_b_n(cs_b1_n), .oe_b_n(oe_b1_n),
    .data_a(data_a1), .data_b(data_b1), .op_a(op_a1), .op_b(op_b1),
    .op_valid(op_valid1), .op_last(op_last1), .op_ready(ready1),
    .busy(busy1), .done(done1)
  );

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    bit found = 0;
    bit seen_done = 0;
    rst = 1'b0; start = 1'b0; op_ready = 1'b0; ovr = 1'b0;
    start1 = 1'b0; ready1 = 1'b0;
    @(negedge clk); @(negedge clk);
    n_total++; if (sram_addr !== 4'd0) $display("FAIL reset_addr: got %h want 0", sram_addr); else n_pass++;
    n_total++; if ({cs_a_n, oe_a_n, cs_b_n, oe_b_n} !== 4'hF) $display("FAIL reset_csoe: got %b want 1111", {cs_a_n, oe_a_n, cs_b_n, oe_b_n}); else n_pass++;
    n_total++; if ({op_a, op_b} !== 32'h0) $display("FAIL reset_ops: got %h want 0", {op_a, op_b}); else n_pass++;
    n_total++; if ({op_valid, op_last, busy, done} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {op_valid, op_last, busy, done}); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    op_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 40 && !found; c++) begin
      if (sram_addr == 4'd3 && !cs_a_n) found = 1;
      else @(negedge clk);
    end
    n_total++; if (found !== 1'b1) $display("FAIL midrun_reach_addr3: got %0d want 1", found); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if ({cs_a_n, oe_a_n, cs_b_n, oe_b_n} !== 4'hF) $display("FAIL midrun_rst_csoe: got %b want 1111", {cs_a_n, oe_a_n, cs_b_n, oe_b_n}); else n_pass++;
    n_total++; if ({op_valid, busy} !== 2'b00) $display("FAIL midrun_rst_valid_busy: got %b want 00", {op_valid, busy}); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (done) seen_done = 1;
      @(negedge clk);
    end
    n_total++; if (seen_done !== 1'b0) $display("FAIL midrun_no_done: got %0d want 0", seen_done); else n_pass++;
    n_total++; if ({sram_addr, busy} !== 5'b0) $display("FAIL midrun_after_release: got addr=%h busy=%b want 0/0", sram_addr, busy); else n_pass++;
  endtask

  task automatic test_full_run();
    int pairs = 0;
    int dones = 0;
    int done_at = -1;
    int first_valid = -1;
    logic [15:0] exp_a, exp_b;
    op_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 60; c++) begin
      if (op_valid) begin
        if (first_valid < 0) first_valid = c;
        exp_a = 16'h3C00 + 16'(pairs);
        exp_b = 16'h4000 + 16'(pairs);
        n_total++; if ({op_a, op_b} !== {exp_a, exp_b}) $display("FAIL run_pair%0d: got %h/%h want %h/%h", pairs, op_a, op_b, exp_a, exp_b); else n_pass++;
        n_total++; if (op_last !== (pairs == 7)) $display("FAIL run_last%0d: got %b want %b", pairs, op_last, (pairs == 7)); else n_pass++;
        pairs++;
      end
      if (done) begin dones++; done_at = c; end
      @(negedge clk);
    end
    n_total++; if (first_valid != 2) $display("FAIL run_first_valid_cycle: got %0d want 2", first_valid); else n_pass++;
    n_total++; if (pairs != 8) $display("FAIL run_pair_count: got %0d want 8", pairs); else n_pass++;
    n_total++; if (dones != 1) $display("FAIL run_done_count: got %0d want 1", dones); else n_pass++;
    n_total++; if (done_at != 24) $display("FAIL run_done_cycle: got %0d want 24", done_at); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit stalled = 0;
    bit seen_done = 0;
    int pairs = 0;
    op_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 80 && !seen_done; c++) begin
      if (op_valid && op_a == 16'h3C02 && !stalled) begin
        op_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          n_total++; if ({op_valid, op_a} !== {1'b1, 16'h3C02}) $display("FAIL bp_hold%0d: got valid=%b a=%h want 1/3c02", s, op_valid, op_a); else n_pass++;
          n_total++; if (sram_addr !== 4'd2) $display("FAIL bp_addr%0d: got %h want 2", s, sram_addr); else n_pass++;
          n_total++; if ({cs_a_n, oe_a_n, cs_b_n, oe_b_n} !== 4'hF) $display("FAIL bp_csoe%0d: got %b want 1111", s, {cs_a_n, oe_a_n, cs_b_n, oe_b_n}); else n_pass++;
        end
        op_ready = 1'b1;
        stalled = 1;
      end
      if (op_valid && op_ready) pairs++;
      if (done) seen_done = 1;
      @(negedge clk);
    end
    n_total++; if (stalled !== 1'b1) $display("FAIL bp_reached_pair2: got %0d want 1", stalled); else n_pass++;
    n_total++; if (pairs != 8) $display("FAIL bp_pair_count: got %0d want 8", pairs); else n_pass++;
    n_total++; if (seen_done !== 1'b1) $display("FAIL bp_done: got %0d want 1", seen_done); else n_pass++;
  endtask

  task automatic test_start_ignored();
    bit pulsed = 0;
    bit d = 0;
    int pairs = 0;
    int dones = 0;
    int busy_cycles = 0;
    op_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 60 && dones == 0; c++) begin
      start = 1'b0;
      if (op_valid && op_a == 16'h3C04 && !pulsed) begin start = 1'b1; pulsed = 1; end
      if (op_valid) pairs++;
      if (done) begin dones++; start = 1'b1; end
      @(negedge clk);
    end
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (busy || op_valid) busy_cycles++;
      @(negedge clk);
    end
    n_total++; if (pairs != 8) $display("FAIL ign_pair_count: got %0d want 8", pairs); else n_pass++;
    n_total++; if (dones != 1) $display("FAIL ign_done_count: got %0d want 1", dones); else n_pass++;
    n_total++; if (busy_cycles != 0) $display("FAIL ign_no_restart: got %0d busy cycles want 0", busy_cycles); else n_pass++;
    pulse_start();
    n_total++; if ({busy, sram_addr} !== {1'b1, 4'd0}) $display("FAIL ign_fresh_start: got busy=%b addr=%h want 1/0", busy, sram_addr); else n_pass++;
    for (int c = 0; c < 60 && !d; c++) begin
      if (done) d = 1;
      @(negedge clk);
    end
    n_total++; if (d !== 1'b1) $display("FAIL ign_fresh_done: got %0d want 1", d); else n_pass++;
  endtask

  task automatic test_timing();
    bit ovr_done = 0;
    bit d = 0;
    int low = 0;
    int runs = 0;
    op_ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 80 && !d; c++) begin
      if ({cs_a_n, oe_a_n, cs_b_n, oe_b_n} == 4'b0) low++;
      else if (low != 0) begin
        n_total++; if (low != 2) $display("FAIL tim_low_len%0d: got %0d want 2", runs, low); else n_pass++;
        runs++;
        low = 0;
      end
      if (op_valid && op_a == 16'h3C00 && !ovr_done) begin
        ovr = 1'b1;
        op_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        n_total++; if ({op_a, op_b} !== {16'h3C00, 16'h4000}) $display("FAIL tim_capture_hold: got %h/%h want 3c00/4000", op_a, op_b); else n_pass++;
        ovr = 1'b0;
        op_ready = 1'b1;
        ovr_done = 1;
      end
      if (done) d = 1;
      @(negedge clk);
    end
    n_total++; if (runs != 8) $display("FAIL tim_run_count: got %0d want 8", runs); else n_pass++;
    n_total++; if (d !== 1'b1) $display("FAIL tim_done: got %0d want 1", d); else n_pass++;
  endtask

  task automatic test_depth1();
    ready1 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n_total++; if ({op_valid1, busy1} !== 2'b01) $display("FAIL d1_read_cycle: got valid=%b busy=%b want 0/1", op_valid1, busy1); else n_pass++;
    @(negedge clk);
    n_total++; if ({op_valid1, op_last1} !== 2'b11) $display("FAIL d1_valid_last: got %b want 11", {op_valid1, op_last1}); else n_pass++;
    n_total++; if ({op_a1, op_b1} !== {16'h3C00, 16'h4000}) $display("FAIL d1_data: got %h/%h want 3c00/4000", op_a1, op_b1); else n_pass++;
    n_total++; if (done1 !== 1'b0) $display("FAIL d1_early_done: got %b want 0", done1); else n_pass++;
    @(negedge clk);
    n_total++; if ({done1, op_valid1} !== 2'b10) $display("FAIL d1_done: got done=%b valid=%b want 1/0", done1, op_valid1); else n_pass++;
    @(negedge clk);
    n_total++; if ({done1, busy1} !== 2'b00) $display("FAIL d1_idle: got done=%b busy=%b want 0/0", done1, busy1); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 16'h3C00 + 16'(i);
      mem_b[i] = 16'h4000 + 16'(i);
    end
    test_reset();
    test_full_run();
    test_backpressure();
    test_start_ignored();
    test_timing();
    test_depth1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
